// File: rtl/baw_card_eval.sv
// Card-evaluation datapath for Black-and-White: colour counts, card-select encoder, hand registers, comparator.
// Optional macro BAW_SEL_ERR_EN adds the sel_err output and blocks loads of invalid selections.
module baw_card_eval (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] p1_card,
  input  logic [8:0] p2_card,
  input  logic [8:0] cardselect,
  input  logic       load_p1,
  input  logic       load_p2,
  input  logic       clear,
  output logic [3:0] p1_black,
  output logic [3:0] p1_white,
  output logic [3:0] p2_black,
  output logic [3:0] p2_white,
  output logic [3:0] p1_handcard,
  output logic [3:0] p2_handcard,
  output logic       p1_isblack,
  output logic       p2_isblack,
  output logic [1:0] matchresult,
  output logic       match_valid
`ifdef BAW_SEL_ERR_EN
  ,
  output logic       sel_err
`endif
);

  localparam int unsigned NCARDS = 9;
  localparam int unsigned CW     = 4;
  localparam int unsigned EW     = 16;

  logic [CW-1:0] p1_hand_q, p1_hand_d;
  logic [CW-1:0] p2_hand_q, p2_hand_d;
  logic          p1_loaded_q, p1_loaded_d;
  logic          p2_loaded_q, p2_loaded_d;
  logic [CW-1:0] sel_enc;
  logic [EW-1:0] sel_ext;
  logic          load_ok;

  // Odd cards are black, even cards are white.
  always_comb begin
    p1_black = '0;
    p1_white = '0;
    p2_black = '0;
    p2_white = '0;
    for (int i = 0; i < NCARDS; i++) begin
      if ((i % 2) == 1) begin
        p1_black = p1_black + CW'(p1_card[i]);
        p2_black = p2_black + CW'(p2_card[i]);
      end else begin
        p1_white = p1_white + CW'(p1_card[i]);
        p2_white = p2_white + CW'(p2_card[i]);
      end
    end
  end

  // Priority encoder: highest set bit wins, all-zero encodes to 0.
  always_comb begin
    sel_ext = {7'b0, cardselect};
    sel_enc = '0;
    for (int i = 0; i < EW; i++) begin
      if (sel_ext[i]) sel_enc = CW'(i);
    end
  end

`ifdef BAW_SEL_ERR_EN
  logic sel_onehot;

  always_comb begin
    sel_onehot = (cardselect != '0) && ((cardselect & (cardselect - 9'd1)) == '0);
    sel_err    = !sel_onehot
               || (load_p1 && ((cardselect & p1_card) == '0))
               || (load_p2 && ((cardselect & p2_card) == '0));
    load_ok    = !sel_err;
  end
`else
  assign load_ok = 1'b1;
`endif

  // Next hand state; clear overrides both loads.
  always_comb begin
    p1_hand_d   = p1_hand_q;
    p2_hand_d   = p2_hand_q;
    p1_loaded_d = p1_loaded_q;
    p2_loaded_d = p2_loaded_q;
    if (clear) begin
      p1_hand_d   = '0;
      p2_hand_d   = '0;
      p1_loaded_d = 1'b0;
      p2_loaded_d = 1'b0;
    end else if (load_ok) begin
      if (load_p1) begin
        p1_hand_d   = sel_enc;
        p1_loaded_d = 1'b1;
      end
      if (load_p2) begin
        p2_hand_d   = sel_enc;
        p2_loaded_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_hand_q   <= '0;
      p2_hand_q   <= '0;
      p1_loaded_q <= 1'b0;
      p2_loaded_q <= 1'b0;
    end else begin
      p1_hand_q   <= p1_hand_d;
      p2_hand_q   <= p2_hand_d;
      p1_loaded_q <= p1_loaded_d;
      p2_loaded_q <= p2_loaded_d;
    end
  end

  // Comparator driven only from registered state, so reset forces 2'b11 at once.
  always_comb begin
    p1_handcard = p1_hand_q;
    p2_handcard = p2_hand_q;
    p1_isblack  = p1_hand_q[0];
    p2_isblack  = p2_hand_q[0];
    match_valid = p1_loaded_q & p2_loaded_q;
    if (!match_valid)                matchresult = 2'b11;
    else if (p1_hand_q > p2_hand_q)  matchresult = 2'b01;
    else if (p2_hand_q > p1_hand_q)  matchresult = 2'b10;
    else                             matchresult = 2'b00;
  end

endmodule

// File: tb/tb_baw_card_eval.sv
// Randomized self-checking bench for baw_card_eval against a rule-level model.
module tb_baw_card_eval;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] p1_card, p2_card, cardselect;
  logic       load_p1, load_p2, clear;
  logic [3:0] p1_black, p1_white, p2_black, p2_white;
  logic [3:0] p1_handcard, p2_handcard;
  logic       p1_isblack, p2_isblack;
  logic [1:0] matchresult;
  logic       match_valid;
`ifdef BAW_SEL_ERR_EN
  logic       sel_err;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state
  int m_h1, m_h2;
  bit m_l1, m_l2;

  always #5 clk = ~clk;

  baw_card_eval dut (
    .clk(clk), .reset_n(reset_n),
    .p1_card(p1_card), .p2_card(p2_card), .cardselect(cardselect),
    .load_p1(load_p1), .load_p2(load_p2), .clear(clear),
    .p1_black(p1_black), .p1_white(p1_white),
    .p2_black(p2_black), .p2_white(p2_white),
    .p1_handcard(p1_handcard), .p2_handcard(p2_handcard),
    .p1_isblack(p1_isblack), .p2_isblack(p2_isblack),
    .matchresult(matchresult), .match_valid(match_valid)
`ifdef BAW_SEL_ERR_EN
    , .sel_err(sel_err)
`endif
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_colour(input logic [8:0] v, input int parity);
    int n = 0;
    for (int c = 0; c < 9; c++) if ((c % 2) == parity && v[c]) n++;
    return n;
  endfunction

  function automatic int top_card(input logic [8:0] v);
    for (int c = 8; c >= 0; c--) if (v[c]) return c;
    return 0;
  endfunction

  function automatic int exp_match();
    if (!(m_l1 && m_l2)) return 3;
    if (m_h1 > m_h2) return 1;
    if (m_h2 > m_h1) return 2;
    return 0;
  endfunction

  function automatic bit exp_err(input logic [8:0] c1, input logic [8:0] c2,
                                 input logic [8:0] sel, input bit l1, input bit l2);
    int ones = 0;
    for (int c = 0; c < 9; c++) if (sel[c]) ones++;
    if (ones != 1) return 1'b1;
    if (l1 && !c1[top_card(sel)]) return 1'b1;
    if (l2 && !c2[top_card(sel)]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_regs(input string tag);
    check_val({tag, ".h1"},  16'(p1_handcard), 16'(m_h1));
    check_val({tag, ".h2"},  16'(p2_handcard), 16'(m_h2));
    check_val({tag, ".b1"},  16'(p1_isblack),  16'(m_h1 % 2));
    check_val({tag, ".b2"},  16'(p2_isblack),  16'(m_h2 % 2));
    check_val({tag, ".mr"},  16'(matchresult), 16'(exp_match()));
    check_val({tag, ".mv"},  16'(match_valid), 16'(m_l1 && m_l2));
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check registers.
  task automatic cycle(input string tag, input logic [8:0] c1, input logic [8:0] c2,
                       input logic [8:0] sel, input bit l1, input bit l2, input bit clr);
    bit ok = 1'b1;
    p1_card = c1; p2_card = c2; cardselect = sel;
    load_p1 = l1; load_p2 = l2; clear = clr;
    #1;
    check_val({tag, ".p1b"}, 16'(p1_black), 16'(count_colour(c1, 1)));
    check_val({tag, ".p1w"}, 16'(p1_white), 16'(count_colour(c1, 0)));
    check_val({tag, ".p2b"}, 16'(p2_black), 16'(count_colour(c2, 1)));
    check_val({tag, ".p2w"}, 16'(p2_white), 16'(count_colour(c2, 0)));
`ifdef BAW_SEL_ERR_EN
    check_val({tag, ".err"}, 16'(sel_err), 16'(exp_err(c1, c2, sel, l1, l2)));
    ok = !exp_err(c1, c2, sel, l1, l2);
`endif
    @(posedge clk);
    if (clr) begin
      m_h1 = 0; m_h2 = 0; m_l1 = 0; m_l2 = 0;
    end else if (ok) begin
      if (l1) begin m_h1 = top_card(sel); m_l1 = 1; end
      if (l2) begin m_h2 = top_card(sel); m_l2 = 1; end
    end
    #1;
    check_regs(tag);
    load_p1 = 0; load_p2 = 0; clear = 0;
  endtask

  initial begin
    logic [8:0] s;
    reset_n = 0; p1_card = '0; p2_card = '0; cardselect = '0;
    load_p1 = 0; load_p2 = 0; clear = 0;
    m_h1 = 0; m_h2 = 0; m_l1 = 0; m_l2 = 0;
    #12;
    check_regs("rst");
    @(negedge clk); reset_n = 1;

    cycle("cnt_a", 9'h1FF, 9'b010101010, 9'h000, 0, 0, 0);
    check_val("cnt_a.p2w0", 16'(p2_white), 16'd0);
    cycle("cnt_b", 9'h1FF, 9'h000,       9'h000, 0, 0, 0);
    cycle("ld5",   9'h1FF, 9'h1FF, 9'b000100000, 1, 0, 0);
    check_val("ld5.lit", 16'(p1_handcard), 16'd5);
    cycle("ld8",   9'h1FF, 9'h1FF, 9'b100000000, 0, 1, 0);
    check_val("ld8.mr_lit", 16'(matchresult), 16'b10);
    cycle("ld7",   9'h1FF, 9'h1FF, 9'b010000000, 1, 0, 0);
    cycle("ld2",   9'h1FF, 9'h1FF, 9'b000000100, 0, 1, 0);
    check_val("7v2.mr_lit", 16'(matchresult), 16'b01);
    cycle("ld44",  9'h1FF, 9'h1FF, 9'b000010000, 1, 1, 0);
    check_val("4v4.mr_lit", 16'(matchresult), 16'b00);
    cycle("prio",  9'h1FF, 9'h1FF, 9'b000010010, 1, 0, 0);
    cycle("zero",  9'h1FF, 9'h1FF, 9'h000,       1, 0, 0);
    cycle("clrld", 9'h1FF, 9'h1FF, 9'b100000000, 1, 0, 1);
    check_val("clrld.lit", 16'(p1_handcard), 16'd0);
`ifdef BAW_SEL_ERR_EN
    cycle("e_ld6", 9'h1FF, 9'h1FF, 9'b001000000, 1, 0, 0);
    cycle("e_two", 9'h1FF, 9'h1FF, 9'b000000011, 1, 0, 0);
    cycle("e_own", 9'h1F7, 9'h1FF, 9'b000001000, 1, 0, 0);
`endif

    // Async reset in mid-cycle with a pending strobe.
    cycle("pre_r", 9'h1FF, 9'h1FF, 9'b000100000, 1, 1, 0);
    @(negedge clk); #2;
    cardselect = 9'b100000000; load_p1 = 1;
    reset_n = 0;
    m_h1 = 0; m_h2 = 0; m_l1 = 0; m_l2 = 0;
    #1;
    check_regs("arst");
    @(posedge clk); #1;
    check_regs("arst_edge");
    load_p1 = 0;
    @(negedge clk); reset_n = 1;

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 1) s = 9'(1 << $urandom_range(0, 8));
      else s = 9'($urandom);
      cycle("rnd", 9'($urandom), 9'($urandom), s,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/baw_card_eval.md
Name: baw_card_eval

Overview:
- Card-evaluation datapath for the Black-and-White two-player card game; sits between the game FSM and the display logic.
- Combines three functions: per-player remaining-card colour counting, one-hot card-select encoding into registered hand cards, and a hand-card comparator producing the match result.
- Cards are numbered 0..8; odd numbers are black, even numbers are white.

Parameters:
- NCARDS, 9, number of cards per player (bit i of a hand vector = card i still held); fixed at 9 for game rules, counts sized 4 bits.

Ports:
- clk  input  1  system clock, all registers rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- p1_card  input  9  player-1 remaining-card vector, bit i = card i unused.
- p2_card  input  9  player-2 remaining-card vector.
- cardselect  input  9  card chosen this turn, intended one-hot.
- load_p1  input  1  strobe: capture encoded cardselect as player-1 hand card.
- load_p2  input  1  strobe: capture encoded cardselect as player-2 hand card.
- clear  input  1  synchronous clear of both hand cards and loaded flags.
- p1_black, p1_white  output  4  counts of black / white cards remaining for player 1.
- p2_black, p2_white  output  4  same for player 2.
- p1_handcard, p2_handcard  output  4  registered played card number (0..8).
- p1_isblack, p2_isblack  output  1  colour of played card (= handcard bit 0).
- matchresult  output  2  comparison of hand cards.
- match_valid  output  1  both hand cards loaded since last reset/clear.

Behaviour:
- Colour count (combinational): black = popcount of bits 1,3,5,7 (range 0..4); white = popcount of bits 0,2,4,6,8 (range 0..5). Vector 9'h1FF gives black=4, white=5; 9'h000 gives 0/0.
- Encoder (combinational): cardselect zero-extended to 16 bits (bits 9..15 = 0) and priority-encoded to 4 bits. The highest set bit wins. All-zero input encodes to 0.
- Hand registers:
  - On a rising clk edge with load_p1=1, p1_handcard takes the encoded value and p1_loaded is set. load_p2 behaves the same for player 2.
  - Simultaneous load_p1 and load_p2 load both registers with the same value.
  - clear has priority over both loads: it zeroes both hand cards and both loaded flags.
  - Latency is 1 cycle from strobe to output.
- Reset (async, reset_n=0): p1_handcard = p2_handcard = 0, loaded flags = 0, matchresult = 2'b11, match_valid = 0. Count outputs follow their inputs combinationally regardless of reset.
- Comparator (combinational, from registered hand cards, unsigned):
  - 2'b01: p1 > p2.
  - 2'b10: p2 > p1.
  - 2'b00: equal.
  - 2'b11: whenever match_valid = 0.
- match_valid = p1_loaded & p2_loaded.
- Reset asserted mid-turn discards any pending strobe in that cycle.
- No other state is held; the block never modifies p1_card / p2_card. The caller removes the played card.

Optional Feature:
- Macro BAW_SEL_ERR_EN.
- Defined: adds output sel_err (1 bit, combinational). It asserts when cardselect is not exactly one-hot. While load_p1=1 it also asserts if the selected card is not set in p1_card; the same check applies to p2_card while load_p2=1. A load with sel_err=1 is ignored: the register and loaded flag stay unchanged.
- Undefined: sel_err port absent, and every load captures the priority-encoded value unconditionally.

Test Plan:
- Counts: p1_card=9'h1FF, p2_card=9'b010101010 -> p1_black=4, p1_white=5, p2_black=4, p2_white=0; p2_card=9'h000 -> 0/0.
- Encode/load: cardselect=9'b000100000 (card 5), pulse load_p1 -> next cycle p1_handcard=5, p1_isblack=1; cardselect=9'b100000000, load_p2 -> p2_handcard=8, p2_isblack=0.
- Compare: hands 5 vs 8 -> matchresult=2'b10, match_valid=1; hands 7 vs 2 -> 2'b01; 4 vs 4 -> 2'b00.
- Priority and zero: cardselect=9'b000010010 -> encoded 4; cardselect=0 with load_p1 -> p1_handcard=0.
- Reset and clear: assert reset_n=0 asynchronously mid-cycle -> hand cards 0, matchresult=2'b11, match_valid=0 immediately; clear together with load_p1 -> hand stays 0.
- With BAW_SEL_ERR_EN: cardselect=9'b000000011 -> sel_err=1 and load ignored; load_p1 for card 3 while p1_card[3]=0 -> sel_err=1, p1_handcard unchanged.
